fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences it against a variable-latency instruction memory. It issues one fetch request at a time and buffers each returned word in a one-entry output register for decode. It applies branch/jump redirects from execute, discarding in-flight or buffered wrong-path instructions. It sits between the imem port and the decode stage of the single-issue RISC-V core.

---
 rtl/fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer_instr_buf.sv | 38 +++
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch sequencer.
//   fetch_state_t : sequencer FSM states
//   INSTR_BYTES   : PC increment per fetched instruction
//   is_aligned()  : 4-byte alignment check on the two address LSBs
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,   // request outstanding
        HOLD,  // buffer full, not fetching
        KILL,  // wrong-path request outstanding, response discarded
        HALT   // misaligned redirect seen, fetch stopped until reset
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic is_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/response bundle.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch address, stable while imem_req high and no imem_ack
//   imem_ack   : memory completes current request (memory -> sequencer)
//   imem_rdata : instruction word, valid with imem_ack
// master = sequencer side, slave = memory side.
interface fetch_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer_instr_buf.sv
// instr_buf: one-entry instruction output register for decode.
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture load_instr/load_pc and mark valid
//   drain            : decode accepted the held entry
//   flush            : invalidate the entry (wins over load and drain)
//   valid/instr/pc   : held entry; instr/pc keep their value when invalidated
module instr_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic             flush,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_pc,
    output logic             valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller owning the program counter.
// Issues one imem request at a time, buffers each returned word for decode,
// and applies execute redirects, discarding wrong-path instructions.
//   clk, rst        : clock, synchronous active-high reset
//   redirect_valid  : taken branch/jump resolved this cycle
//   redirect_target : new fetch address
//   imem            : instruction-memory bundle (master side)
//   instr_valid     : instr/instr_pc hold a valid instruction
//   instr, instr_pc : buffered instruction and its address
//   decode_ready    : decode accepts when instr_valid is also high
//   fetch_fault     : sticky, misaligned redirect received and fetch halted
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [WIDTH-1:0]    redirect_target,
    fetch_sequencer_if.master   imem,
    output logic                instr_valid,
    output logic [WIDTH-1:0]    instr,
    output logic [WIDTH-1:0]    instr_pc,
    input  logic                decode_ready,
    output logic                fetch_fault
);

    fetch_state_t     state, state_nxt;
    logic [WIDTH-1:0] addr_q, addr_nxt;
    logic [WIDTH-1:0] pend_q, pend_nxt;
    logic             fault_q, fault_nxt;
    logic             buf_load, buf_flush;
    logic             ack, drain, redir_ok, redir_bad;

    assign imem.imem_req  = !rst && (state == REQ || state == KILL);
    assign imem.imem_addr = addr_q;
    assign fetch_fault    = fault_q;

    assign ack       = imem.imem_ack && imem.imem_req;
    assign drain     = instr_valid && decode_ready;
    assign redir_ok  = redirect_valid &&  is_aligned(redirect_target[1:0]);
    assign redir_bad = redirect_valid && !is_aligned(redirect_target[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= REQ;
            addr_q  <= RESET_PC;
            pend_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            pend_q  <= pend_nxt;
            fault_q <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        pend_nxt  = pend_q;
        fault_nxt = fault_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;

        if (state != HALT && redir_bad) begin
            state_nxt = HALT;
            fault_nxt = 1'b1;
            buf_flush = 1'b1;
        end else if (state != HALT && redir_ok) begin
            buf_flush = 1'b1;
            // With no response pending (HOLD) or the response arriving now,
            // the target can be fetched immediately; otherwise park it until
            // the wrong-path response has been swallowed.
            if (state == HOLD || ack) begin
                addr_nxt  = redirect_target;
                state_nxt = REQ;
            end else begin
                pend_nxt  = redirect_target;
                state_nxt = KILL;
            end
        end else begin
            unique case (state)
                REQ: begin
                    if (ack) begin
                        // A word arriving while the buffer is full and not
                        // draining has nowhere to go: drop it, keep addr so
                        // the same instruction is refetched once decode
                        // takes the buffered one.
                        if (!instr_valid || drain) begin
                            buf_load = 1'b1;
                            addr_nxt = addr_q + WIDTH'(INSTR_BYTES);
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (drain) state_nxt = REQ;
                end
                KILL: begin
                    if (ack) begin
                        addr_nxt  = pend_q;
                        state_nxt = REQ;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
            endcase
        end
    end

    instr_buf #(
        .WIDTH (WIDTH)
    ) u_instr_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .drain      (drain),
        .flush      (buf_flush),
        .load_instr (imem.imem_rdata),
        .load_pc    (addr_q),
        .valid      (instr_valid),
        .instr      (instr),
        .pc         (instr_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer.
// Memory responses carry rdata = address + 0x1000_0000 so expected
// instruction words follow directly from the fetch address.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    fetch_sequencer_if #(.WIDTH(32)) bus ();

    fetch_sequencer #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (bus.master),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .decode_ready    (decode_ready),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then wait for the next falling edge.
    task automatic cyc(input logic a, input logic dr, input logic rv, input logic [31:0] rt);
        bus.imem_ack    = a;
        bus.imem_rdata  = bus.imem_addr + 32'h1000_0000;
        decode_ready    = dr;
        redirect_valid  = rv;
        redirect_target = rt;
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        decode_ready    = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        @(negedge clk);
        @(negedge clk);

        // reset values
        chk("rst_req",   bus.imem_req,  32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_valid", instr_valid,   32'd0);
        chk("rst_instr", instr,         32'h0);
        chk("rst_pc",    instr_pc,      32'h0);
        chk("rst_fault", fetch_fault,   32'd0);

        rst = 1'b0;
        #1;
        chk("first_req",  bus.imem_req,  32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);

        // streaming: ack every cycle, decode always ready
        cyc(1, 1, 0, 0);
        chk("s0_valid", instr_valid,   32'd1);
        chk("s0_pc",    instr_pc,      32'h0);
        chk("s0_instr", instr,         32'h1000_0000);
        chk("s0_addr",  bus.imem_addr, 32'h4);
        cyc(1, 1, 0, 0);
        chk("s1_valid", instr_valid,   32'd1);
        chk("s1_pc",    instr_pc,      32'h4);
        chk("s1_instr", instr,         32'h1000_0004);
        chk("s1_addr",  bus.imem_addr, 32'h8);
        cyc(1, 1, 0, 0);
        chk("s2_pc",    instr_pc,      32'h8);
        chk("s2_addr",  bus.imem_addr, 32'hC);

        // reset mid-stream
        rst = 1'b1;
        #1;
        chk("mid_rst_req", bus.imem_req, 32'd0);
        @(negedge clk);
        chk("mid_rst_valid", instr_valid,   32'd0);
        chk("mid_rst_addr",  bus.imem_addr, 32'h0);
        rst = 1'b0;

        // decode stall after first ack
        cyc(1, 0, 0, 0);
        chk("d1_valid", instr_valid,   32'd1);
        chk("d1_pc",    instr_pc,      32'h0);
        chk("d1_addr",  bus.imem_addr, 32'h4);
        chk("d1_req",   bus.imem_req,  32'd1);
        cyc(1, 0, 0, 0);
        chk("d2_req",   bus.imem_req,  32'd0);
        chk("d2_addr",  bus.imem_addr, 32'h4);
        chk("d2_pc",    instr_pc,      32'h0);
        chk("d2_valid", instr_valid,   32'd1);
        cyc(0, 0, 0, 0);
        chk("d3_req", bus.imem_req, 32'd0);
        chk("d3_pc",  instr_pc,     32'h0);
        cyc(0, 0, 0, 0);
        chk("d4_req", bus.imem_req, 32'd0);
        chk("d4_pc",  instr_pc,     32'h0);
        cyc(0, 1, 0, 0);
        chk("d5_req",   bus.imem_req,  32'd1);
        chk("d5_addr",  bus.imem_addr, 32'h4);
        chk("d5_valid", instr_valid,   32'd0);
        cyc(1, 1, 0, 0);
        chk("d6_valid", instr_valid,   32'd1);
        chk("d6_pc",    instr_pc,      32'h4);
        chk("d6_instr", instr,         32'h1000_0004);
        chk("d6_addr",  bus.imem_addr, 32'h8);

        // redirect while 0x8 outstanding; latest target wins in KILL
        cyc(0, 1, 1, 32'h200);
        chk("k1_req",   bus.imem_req,  32'd1);
        chk("k1_addr",  bus.imem_addr, 32'h8);
        chk("k1_valid", instr_valid,   32'd0);
        cyc(0, 0, 1, 32'h100);
        chk("k2_req",   bus.imem_req,  32'd1);
        chk("k2_addr",  bus.imem_addr, 32'h8);
        chk("k2_valid", instr_valid,   32'd0);
        cyc(1, 0, 0, 0);
        chk("k3_valid", instr_valid,   32'd0);
        chk("k3_addr",  bus.imem_addr, 32'h100);
        chk("k3_req",   bus.imem_req,  32'd1);
        cyc(1, 0, 0, 0);
        chk("k4_valid", instr_valid,   32'd1);
        chk("k4_pc",    instr_pc,      32'h100);
        chk("k4_instr", instr,         32'h1000_0100);
        chk("k4_addr",  bus.imem_addr, 32'h104);

        // redirect with full buffer and same-cycle ack
        cyc(1, 0, 1, 32'h40);
        chk("r1_valid", instr_valid,   32'd0);
        chk("r1_addr",  bus.imem_addr, 32'h40);
        chk("r1_req",   bus.imem_req,  32'd1);
        cyc(1, 0, 0, 0);
        chk("r2_valid", instr_valid,   32'd1);
        chk("r2_pc",    instr_pc,      32'h40);
        chk("r2_addr",  bus.imem_addr, 32'h44);
        cyc(1, 0, 0, 0);
        chk("r3_req",   bus.imem_req,  32'd0);
        chk("r3_addr",  bus.imem_addr, 32'h44);
        chk("r3_pc",    instr_pc,      32'h40);

        // redirect from HOLD to the top of the address space, then wrap
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        chk("h1_req",   bus.imem_req,  32'd1);
        chk("h1_addr",  bus.imem_addr, 32'hFFFF_FFFC);
        chk("h1_valid", instr_valid,   32'd0);
        cyc(1, 1, 0, 0);
        chk("w_valid", instr_valid,   32'd1);
        chk("w_pc",    instr_pc,      32'hFFFF_FFFC);
        chk("w_instr", instr,         32'h0FFF_FFFC);
        chk("w_addr",  bus.imem_addr, 32'h0);

        // misaligned redirect halts fetch
        cyc(0, 0, 1, 32'h102);
        chk("f1_fault", fetch_fault,   32'd1);
        chk("f1_req",   bus.imem_req,  32'd0);
        chk("f1_valid", instr_valid,   32'd0);
        chk("f1_addr",  bus.imem_addr, 32'h0);
        cyc(1, 1, 1, 32'h200);
        chk("f2_fault", fetch_fault,   32'd1);
        chk("f2_req",   bus.imem_req,  32'd0);
        chk("f2_addr",  bus.imem_addr, 32'h0);
        chk("f2_pc",    instr_pc,      32'hFFFF_FFFC);
        chk("f2_valid", instr_valid,   32'd0);

        // reset clears the fault and refetches RESET_PC
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        chk("fr_fault", fetch_fault,  32'd0);
        chk("fr_req",   bus.imem_req, 32'd0);
        rst = 1'b0;
        #1;
        chk("fr2_req",  bus.imem_req,  32'd1);
        chk("fr2_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        cyc(1, 1, 0, 0);
        chk("fr3_valid", instr_valid,   32'd1);
        chk("fr3_pc",    instr_pc,      32'h0);
        chk("fr3_addr",  bus.imem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
